rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
- Multi-source reset controller; parametrised successor to the two-flop async-in/sync-out reset synchroniser.
- Each asynchronous active-low reset request passes through an N-stage synchroniser and a glitch filter.
- Any active request holds all output resets asserted; after a minimum hold period the outputs are released one by one in a fixed order with a programmable gap.
- Sits at top level and drives the per-subsystem synchronous resets (UART core, baud generator, FIFOs, ...).

Parameters:
- SYNC_STAGES, 2, synchroniser flops per source (must be >=2).
- NUM_SRC, 2, number of asynchronous reset request inputs (>=1).
- NUM_OUT, 3, number of sequenced reset outputs (>=1).
- FILTER_CYCLES, 4, consecutive agreeing samples required to change the filtered request state (>=1).
- HOLD_CYCLES, 16, consecutive request-free cycles required before release starts (>=1).
- RELEASE_GAP, 8, cycles between successive output deassertions (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  master reset, synchronous, active-low.
- src_rst_n  input  NUM_SRC  asynchronous reset requests, active-low.
- sw_rst  input  1  synchronous software reset request, active-high, single-cycle or level.
- cause_clr  input  1  synchronous clear of the cause register.
- rst_out  output  NUM_OUT  sequenced synchronous resets, active-high; bit 0 is released first.
- all_released  output  1  high when every rst_out bit is deasserted.
- cause  output  NUM_SRC+1  sticky reset-cause flags; bit i is src i, bit NUM_SRC is sw_rst.

Behaviour:
- Master reset (rst=0 at an edge) sets the following state:
  - all synchroniser flops = 0 (request active);
  - filtered requests = active, filter counters = 0;
  - FSM = HOLD, hold and gap counters = 0;
  - rst_out = all 1s, all_released = 0, cause = 0.
- Synchroniser: plain shift chain per source. Edge 1 samples src_rst_n; the value appears at the chain output after edge SYNC_STAGES.
- Filter, per source:
  - The counter increments on each edge where the synchroniser output differs from the filtered state, and clears when they agree.
  - On the FILTER_CYCLES-th consecutive differing edge, the filtered state flips and the counter clears.
  - Differing runs shorter than FILTER_CYCLES are ignored.
  - The filter is symmetric for assertion and deassertion.
- any_req = OR of the filtered requests OR sw_rst. sw_rst bypasses the synchroniser and filter.
- FSM:
  - HOLD:
    - rst_out all 1s.
    - The hold counter increments on each edge with any_req=0 and clears on any_req=1.
    - On the HOLD_CYCLES-th consecutive clear edge: go to RELEASE; rst_out[0] deasserts on that same edge; gap counter = 0.
  - RELEASE:
    - Every RELEASE_GAP edges, deassert the next rst_out bit in ascending index order.
    - On the edge that deasserts bit NUM_OUT-1, go to RUN and set all_released=1 on that same edge.
    - If NUM_OUT=1, HOLD goes directly to RUN.
  - RUN: outputs stay deasserted.
  - From RELEASE or RUN, any_req=1 at an edge gives HOLD on that edge: all rst_out=1, all_released=0, counters cleared. A partial release is aborted; the full hold restarts.
- Latency, source assert to rst_out asserted: exactly SYNC_STAGES+FILTER_CYCLES+1 edges from the first edge sampling low (7 with defaults).
- Latency, sw_rst to rst_out asserted: 1 edge.
- Cause register:
  - Bit i sets on the edge where filtered request i becomes active. Bit NUM_SRC sets on any edge with sw_rst=1.
  - cause_clr clears all bits. Set wins over clear in the same cycle.
  - The master reset clears cause; requests present at power-up do not set cause until they have been released and then re-asserted.
- rst_out and all_released are registered outputs with no combinational path from any input.
- Counter widths: $clog2(max+1) of the respective parameter.

Test Plan:
- Power-up, defaults, src_rst_n=2'b11 from start, rst released at edge 0 → rst_out[0] falls at edge 22, rst_out[1] at 30, rst_out[2] and all_released at 38; cause=0.
- In RUN, src_rst_n[1] low for 3 cycles → no change on rst_out; cause=0. Low for 4 cycles → rst_out=3'b111 exactly 7 edges after the first low sample; cause=3'b010.
- Pulse sw_rst one cycle during RELEASE, after rst_out[0] has fallen → rst_out=3'b111 next edge; release restarts with the 16-cycle hold; cause[2]=1.
- sw_rst and cause_clr high in the same cycle → cause[2]=1. Next cycle cause_clr alone → cause=0.
- src_rst_n[0] held low continuously → rst_out stays 3'b111 indefinitely. Release it → rst_out[0] falls 2+4+16=22 edges later.
- rst driven low mid-RELEASE → next edge rst_out=3'b111, all_released=0, cause=0, and the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/rst_sequencer.sv
// Multi-source reset sequencer: synchronise and de-glitch async reset requests,
// hold all resets while any request is active, then release outputs in order.
module rst_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_SRC       = 2,
  parameter int NUM_OUT       = 3,
  parameter int FILTER_CYCLES = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int RELEASE_GAP   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_rst_n,
  input  logic               sw_rst,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               all_released,
  output logic [NUM_SRC:0]   cause
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(RELEASE_GAP + 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [NUM_SRC-1:0] filt_req;
  logic [NUM_SRC-1:0] filt_rise;
  logic               any_req;

  // Per-source synchroniser chain followed by a symmetric run-length filter.
  // Filtered state is active-high: 1 means the source is requesting reset.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   filt_reg;
      logic [FW-1:0]          fcnt_reg;
      logic                   sync_req;
      logic                   fcnt_last;

      assign sync_req  = ~sync_reg[SYNC_STAGES-1];
      assign fcnt_last = (fcnt_reg == FW'(FILTER_CYCLES - 1));

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_reg <= '0;
          filt_reg <= 1'b1;
          fcnt_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], src_rst_n[gi]};
          if (sync_req == filt_reg) begin
            fcnt_reg <= '0;
          end else if (fcnt_last) begin
            filt_reg <= sync_req;
            fcnt_reg <= '0;
          end else begin
            fcnt_reg <= fcnt_reg + 1'b1;
          end
        end
      end

      assign filt_req[gi]  = filt_reg;
      assign filt_rise[gi] = sync_req & ~filt_reg & fcnt_last;
    end
  endgenerate

  assign any_req = (|filt_req) | sw_rst;

  state_t             state_reg,   state_next;
  logic [HW-1:0]      hold_reg,    hold_next;
  logic [GW-1:0]      gap_reg,     gap_next;
  logic [NUM_OUT-1:0] rst_out_reg, rst_out_next;
  logic               all_rel_reg, all_rel_next;
  logic [NUM_SRC:0]   cause_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_HOLD;
      hold_reg    <= '0;
      gap_reg     <= '0;
      rst_out_reg <= '1;
      all_rel_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      gap_reg     <= gap_next;
      rst_out_reg <= rst_out_next;
      all_rel_reg <= all_rel_next;
    end
  end

  // Release shifts a zero in from bit 0, so outputs deassert in ascending order;
  // an all-zero result means the last output has just been released.
  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    gap_next     = gap_reg;
    rst_out_next = rst_out_reg;
    all_rel_next = all_rel_reg;
    if (any_req) begin
      state_next   = ST_HOLD;
      hold_next    = '0;
      gap_next     = '0;
      rst_out_next = '1;
      all_rel_next = 1'b0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (hold_reg == HW'(HOLD_CYCLES - 1)) begin
            hold_next    = '0;
            gap_next     = '0;
            rst_out_next = rst_out_reg << 1;
            if (rst_out_next == '0) begin
              state_next   = ST_RUN;
              all_rel_next = 1'b1;
            end else begin
              state_next = ST_RELEASE;
            end
          end else begin
            hold_next = hold_reg + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_reg == GW'(RELEASE_GAP - 1)) begin
            gap_next     = '0;
            rst_out_next = rst_out_reg << 1;
            if (rst_out_next == '0) begin
              state_next   = ST_RUN;
              all_rel_next = 1'b1;
            end
          end else begin
            gap_next = gap_reg + 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_next   = ST_HOLD;
          hold_next    = '0;
          gap_next     = '0;
          rst_out_next = '1;
          all_rel_next = 1'b0;
        end
      endcase
    end
  end

  // Set has priority over clear so a request coinciding with a clear is kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cause_reg <= '0;
    end else begin
      cause_reg <= (cause_clr ? '0 : cause_reg) | {sw_rst, filt_rise};
    end
  end

  assign rst_out      = rst_out_reg;
  assign all_released = all_rel_reg;
  assign cause        = cause_reg;

endmodule
